// File: rtl/req_burst_pkg.sv
// req_burst_pkg: shared client state encoding and parameter legality helper for req_burst_shaper
package req_burst_pkg;

    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        BACKOFF = 2'd2
    } client_state_t;

    function automatic bit params_ok(input int burst, input int backoff_cyc);
        return (burst >= 1) && (backoff_cyc >= 2);
    endfunction

endpackage

// File: rtl/req_client_ctrl.sv
// req_client_ctrl: one client's pending counter, burst/backoff FSM and sticky overflow flag
module req_client_ctrl
    import req_burst_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int BURST       = 4,
    parameter int BACKOFF_CYC = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_pulse,
    input  logic             g,
    output logic             r,
    output logic             beat,
    output logic [CNT_W-1:0] cnt,
    output logic             overflow
);

    localparam int BW = $clog2(BURST + 1);
    localparam int OW = $clog2(BACKOFF_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [BW-1:0] BURST_V = BW'(BURST);
    localparam logic [OW-1:0] BO_LOAD = OW'(BACKOFF_CYC - 1);

    if (!params_ok(BURST, BACKOFF_CYC)) begin : g_bad_params
        $error("req_client_ctrl: BURST must be >= 1 and BACKOFF_CYC >= 2");
    end

    client_state_t   state, state_next;
    logic [BW-1:0]    bcnt, bcnt_next;
    logic [OW-1:0]    bo, bo_next;
    logic [CNT_W-1:0] cnt_next;
    logic             drop;

    assign r    = (state == ACTIVE);
    assign beat = g & r;
    assign drop = req_pulse & ~beat & (cnt == CNT_MAX);
    assign cnt_next = (req_pulse & ~beat & ~drop) ? cnt + CNT_W'(1) :
                      (beat & ~req_pulse)         ? cnt - CNT_W'(1) : cnt;

    // draining to zero wins over the burst limit
    always_comb begin
        state_next = state;
        bcnt_next  = beat ? bcnt + BW'(1) : bcnt;
        bo_next    = bo;
        case (state)
            IDLE: begin
                if (cnt_next != '0) begin
                    state_next = ACTIVE;
                    bcnt_next  = '0;
                end
            end
            ACTIVE: begin
                if (cnt_next == '0) begin
                    state_next = IDLE;
                end else if (bcnt_next == BURST_V) begin
                    state_next = BACKOFF;
                    bo_next    = BO_LOAD;
                end
            end
            BACKOFF: begin
                if (bo != '0) begin
                    bo_next = bo - OW'(1);
                end else begin
                    state_next = (cnt_next != '0) ? ACTIVE : IDLE;
                    bcnt_next  = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            bcnt     <= '0;
            bo       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            bcnt     <= bcnt_next;
            bo       <= bo_next;
            cnt      <= cnt_next;
            overflow <= overflow | drop;
        end
    end

endmodule

// File: rtl/req_burst_shaper.sv
// req_burst_shaper: per-client request conditioner giving bounded starvation ahead of a fixed-priority arbiter
module req_burst_shaper
    import req_burst_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int BURST       = 4,
    parameter int BACKOFF_CYC = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req_pulse,
    input  logic [NUM_REQ-1:0]       g,
    output logic [NUM_REQ-1:0]       r,
    output logic [NUM_REQ-1:0]       beat,
    output logic [NUM_REQ*CNT_W-1:0] pend_cnt,
    output logic [NUM_REQ-1:0]       overflow
);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_client
        req_client_ctrl #(
            .CNT_W      (CNT_W),
            .BURST      (BURST),
            .BACKOFF_CYC(BACKOFF_CYC)
        ) u_ctrl (
            .clk      (clk),
            .resetn   (resetn),
            .req_pulse(req_pulse[i]),
            .g        (g[i]),
            .r        (r[i]),
            .beat     (beat[i]),
            .cnt      (pend_cnt[i*CNT_W +: CNT_W]),
            .overflow (overflow[i])
        );
    end

endmodule
